// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// stalls the pipeline until {remainder, quotient} is ready for HI/LO.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_req_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   rem_sh, trial;
  logic             step_done;

  // Operand magnitudes; signs are reapplied once all quotient bits exist.
  assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

  // rem < divisor always holds, so the shifted remainder fits in WIDTH+1 bits
  // and the MSB of the trial difference is a valid sign.
  assign rem_sh    = {rem, quo[WIDTH-1]};
  assign trial     = rem_sh - {1'b0, divisor};
  assign step_done = (cnt == CW'(WIDTH));

  always_comb begin
    state_next  = state;
    stall_req_o = start_i & ~annul_i & (state != S_END);
    case (state)
      S_IDLE: begin
        if (start_i && !annul_i)
          state_next = (opdata2_i == '0) ? S_BYZERO : S_ON;
      end
      S_BYZERO: state_next = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i)        state_next = S_IDLE;
        else if (step_done) state_next = S_END;
      end
      S_END: begin
        if (annul_i || !start_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          cnt      <= '0;
          if (state_next == S_ON) begin
            rem     <= '0;
            quo     <= mag1;
            divisor <= mag2;
            neg_q   <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r   <= signed_div_i & opdata1_i[WIDTH-1];
          end
        end
        S_BYZERO: begin
          ready_o  <= (state_next == S_END);
          result_o <= '0;
        end
        S_ON: begin
          if (annul_i) begin
            cnt <= '0;
          end else if (!step_done) begin
            rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            cnt <= cnt + CW'(1);
          end else begin
            cnt      <= '0;
            ready_o  <= 1'b1;
            result_o <= {(neg_r ? (~rem + WIDTH'(1)) : rem),
                         (neg_q ? (~quo + WIDTH'(1)) : quo)};
          end
        end
        S_END: begin
          if (state_next == S_IDLE) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: an arithmetic reference model feeds an
// expected queue; one negedge process compares ready/result/stall every cycle.
module tb_div_seq;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stall_req_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [2*W-1:0] exp_q[$];
  logic           exp_ready = 1'b0;
  logic [2*W-1:0] exp_res = '0;
  logic           chk_en = 1'b0;

  div_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stall_req_o  (stall_req_o)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, truncating toward zero.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sgn);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready_o", {63'b0, ready_o}, {63'b0, exp_ready});
      chk("result_o", result_o, exp_ready ? exp_res : '0);
      chk("stall_req_o", {63'b0, stall_req_o}, {63'b0, start_i & ~annul_i & ~exp_ready});
    end
  end

  // Full division; operands are scrambled after the start edge to prove they are latched.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input int hold, input bit scramble);
    int lat;
    lat = (b == '0) ? 2 : W + 2;
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sgn;
    start_i      = 1'b1;
    exp_q.push_back(model(a, b, sgn));
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k == 1 && scramble) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
      if (k == lat) begin
        exp_res   = exp_q.pop_front();
        exp_ready = 1'b1;
      end
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    exp_ready = 1'b0;
    exp_res   = '0;
  endtask

  // Division aborted by an annul pulse landing on edge k.
  task automatic run_annul(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                           input int k);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sgn;
    start_i      = 1'b1;
    repeat (k - 1) begin
      @(posedge clk); #1;
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;
    int           sel;

    // Pin the reference model against hand-computed results.
    chk("model_100_7", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    chk("model_m7_2", model(32'hFFFFFFF9, 32'd2, 1'b1), {32'hFFFFFFFF, 32'hFFFFFFFD});
    chk("model_7_m2", model(32'd7, 32'hFFFFFFFE, 1'b1), {32'd1, 32'hFFFFFFFD});
    chk("model_ovf", model(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'd0, 32'h80000000});
    chk("model_max_1", model(32'hFFFFFFFF, 32'd1, 1'b0), {32'd0, 32'hFFFFFFFF});
    chk("model_by0", model(32'h1234, 32'd0, 1'b0), 64'd0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready", {63'b0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk_en = 1'b1;
    @(posedge clk); #1;

    run_div(32'd100, 32'd7, 1'b0, 2, 1'b1);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 0, 1'b1);
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, 1, 1'b1);
    run_div(32'h1234, 32'd0, 1'b0, 1, 1'b1);
    run_annul(32'd100, 32'd7, 1'b0, 11);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 0, 1'b1);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1, 1'b1);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 1'b1);

    // Reset lands on edge 20; start stays high so a fresh division follows.
    opdata1_i    = 32'd5000;
    opdata2_i    = 32'hFFFFFFFD;
    signed_div_i = 1'b1;
    start_i      = 1'b1;
    repeat (19) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_ready", {63'b0, ready_o}, 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    run_div(32'd5000, 32'hFFFFFFFD, 1'b1, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 5);
      a   = $urandom;
      s   = 1'($urandom_range(0, 1));
      case (sel)
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       begin a = 32'h80000000; b = $urandom; end
        default: b = $urandom;
      endcase
      if (i % 7 == 3) run_annul(a, (b == '0) ? 32'd3 : b, s, $urandom_range(2, 30));
      else            run_div(a, b, s, $urandom_range(0, 3), 1'b1);
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
